store_align_unit: RTL and testbench

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/store_align_unit.sv | 123 ++++++++++++
 tb/tb_store_align_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a byte/halfword/word store into one lane-aligned,
// byte-enabled memory write, with alignment checking and a bounded wait for mem_ready.
module store_align_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        busy,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (size)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {24'h0, wdata_in[7:0]} << {addr[1:0], 3'b000};
      end
      2'b01: begin
        w_legal = ~addr[0];
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = addr[1] ? {wdata_in[15:0], 16'h0} : {16'h0, wdata_in[15:0]};
      end
      2'b10: begin
        w_legal = (addr[1:0] == 2'b00);
        w_be    = 4'b1111;
        w_wdata = wdata_in;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_be      <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          err_align <= 1'b0;
          if (start && w_legal) begin
            r_state   <= S_WRITE;
            r_cnt     <= '0;
            mem_we    <= 1'b1;
            busy      <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
          end else if (start) begin
            err_align <= 1'b1;
          end
        end
        S_WRITE: begin
          // Bus outputs drop together with mem_we so they read 0 outside a write.
          if (mem_ready || r_cnt == LAST_CNT) begin
            r_state     <= mem_ready ? S_DONE : S_ERR;
            done        <= mem_ready;
            err_timeout <= ~mem_ready;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_be      <= 4'b0000;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          err_timeout <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: table of single stores plus hand-written
// timeout, late-ready, ignored-start and reset-abort sequences.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        done;
  logic        err_align;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  store_align_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .wdata_in(wdata_in), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .busy(busy), .done(done), .err_align(err_align), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {31'h0, |{mem_we, mem_addr, mem_wdata, mem_be, busy, done, err_align, err_timeout}}, 32'h0);
  endtask

  initial begin
    int we_cycles;
    int guard;

    vecs[0] = '{2'b00, 32'h0000_1003, 32'h1234_56AB, 1'b0, 32'h0000_1000, 4'b1000, 32'hAB00_0000};
    vecs[1] = '{2'b00, 32'h0000_1000, 32'h1234_56AB, 1'b0, 32'h0000_1000, 4'b0001, 32'h0000_00AB};
    vecs[2] = '{2'b00, 32'h0000_1001, 32'h1234_56AB, 1'b0, 32'h0000_1000, 4'b0010, 32'h0000_AB00};
    vecs[3] = '{2'b01, 32'h0000_2002, 32'hFFFF_BEEF, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_0000};
    vecs[4] = '{2'b01, 32'h0000_2000, 32'hFFFF_BEEF, 1'b0, 32'h0000_2000, 4'b0011, 32'h0000_BEEF};
    vecs[5] = '{2'b01, 32'h0000_2001, 32'hFFFF_BEEF, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[6] = '{2'b10, 32'h0000_3002, 32'h1111_2222, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[7] = '{2'b10, 32'h0000_3001, 32'h1111_2222, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[8] = '{2'b11, 32'h0000_3000, 32'h1111_2222, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[9] = '{2'b10, 32'h0000_3004, 32'hCAFE_F00D, 1'b0, 32'h0000_3004, 4'b1111, 32'hCAFE_F00D};

    reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'h0; wdata_in = 32'h0; mem_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset_outputs");
    reset = 1'b0;

    // Single stores with mem_ready already high.
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      size = vecs[i].size; addr = vecs[i].addr; wdata_in = vecs[i].wdata; start = 1'b1;
      tick();
      start = 1'b0;
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_err_align", i), {31'h0, err_align}, 32'h1);
        check($sformatf("v%0d_no_we", i), {31'h0, mem_we}, 32'h0);
        check($sformatf("v%0d_not_busy", i), {31'h0, busy}, 32'h0);
        tick();
        check($sformatf("v%0d_err_pulse_end", i), {30'h0, err_align, mem_we}, 32'h0);
      end else begin
        check($sformatf("v%0d_we", i), {30'h0, mem_we, busy}, 32'h3);
        check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_be", i), {28'h0, mem_be}, {28'h0, vecs[i].exp_be});
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
        tick();
        check($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
        check($sformatf("v%0d_done_bus_zero", i), {31'h0, |{mem_we, busy, mem_addr, mem_wdata, mem_be}}, 32'h0);
        tick();
        check($sformatf("v%0d_done_pulse_end", i), {31'h0, done}, 32'h0);
      end
    end

    // Timeout: memory never answers.
    mem_ready = 1'b0; size = 2'b10; addr = 32'h0000_4000; wdata_in = 32'h5555_AAAA; start = 1'b1;
    tick();
    start = 1'b0;
    we_cycles = 0;
    guard = 0;
    while (mem_we === 1'b1 && guard < 40) begin
      if (mem_addr !== 32'h0000_4000 || mem_be !== 4'b1111 || mem_wdata !== 32'h5555_AAAA)
        check("to_bus_stable", 32'h1, 32'h0);
      we_cycles++;
      guard++;
      tick();
    end
    check("to_we_cycles", we_cycles, 16);
    check("to_err_timeout", {30'h0, err_timeout, done}, 32'h2);
    tick();
    check_all_zero("to_back_idle");

    // Ready on the 16th WRITE cycle wins; extra starts during WRITE and DONE are dropped.
    size = 2'b10; addr = 32'h0000_4100; wdata_in = 32'h0BAD_F00D; start = 1'b1;
    tick();
    we_cycles = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 5) start = 1'b0;
      we_cycles += int'(mem_we);
      tick();
    end
    start = 1'b0;
    we_cycles += int'(mem_we);
    mem_ready = 1'b1;
    tick();
    check("late_we_cycles", we_cycles, 16);
    check("late_done_not_to", {30'h0, done, err_timeout}, 32'h2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_dropped", {30'h0, mem_we, busy}, 32'h0);
    tick();
    check("no_second_burst", {30'h0, mem_we, done}, 32'h0);

    // Reset on the 3rd WRITE cycle aborts without done.
    mem_ready = 1'b0; size = 2'b10; addr = 32'h0000_5000; wdata_in = 32'h7777_7777; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rst_pre_in_write", {31'h0, mem_we}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_abort_zero");
    tick();
    check_all_zero("rst_no_done");

    mem_ready = 1'b1; size = 2'b10; addr = 32'h0000_0010; wdata_in = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_be", {28'h0, mem_be}, 32'hF);
    check("post_rst_data", mem_wdata, 32'hDEAD_BEEF);
    check("post_rst_addr", mem_addr, 32'h0000_0010);
    tick();
    check("post_rst_done", {31'h0, done}, 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
